// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// reset_seq_pkg : sequencer state encoding and default timing constants
// Rev 1.0
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_RELEASE    = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_GAP        = 3'd3,
        ST_DONE       = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    localparam int C_N_STAGES      = 3;
    localparam int C_HOLD_CYCLES   = 120;
    localparam int C_GAP_CYCLES    = 12;
    localparam int C_READY_TIMEOUT = 1200;
    localparam int C_CNT_W         = 11;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// reset_sequencer_if : per-stage reset/ack bundle plus status outputs
// Rev 1.0
// ============================================================================
interface reset_sequencer_if import reset_seq_pkg::*; #(
    parameter int N_STAGES = C_N_STAGES
) ();
    localparam int IDX_W = idx_width(N_STAGES);

    logic                swResetReq;
    logic [N_STAGES-1:0] stageReady;
    logic [N_STAGES-1:0] stageRstN;
    logic                sysReady;
    logic                fault;
    logic [IDX_W-1:0]    faultStage;

    modport master (
        output swResetReq, stageReady,
        input  stageRstN, sysReady, fault, faultStage
    );

    modport slave (
        input  swResetReq, stageReady,
        output stageRstN, sysReady, fault, faultStage
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer_cycle_timer.sv
`default_nettype none
// ============================================================================
// cycle_timer : saturating up-counter with terminal-count compare
// Rev 1.0
// ============================================================================
module cycle_timer import reset_seq_pkg::*; #(
    parameter int CNT_W = C_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             clear,
    input  wire logic             enable,
    input  wire logic [CNT_W-1:0] limit,
    output logic                  tc
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == limit);
endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// reset_sequencer : ordered per-stage reset release with ack timeout/loss fault
// Rev 1.0
// ============================================================================
module reset_sequencer import reset_seq_pkg::*; #(
    parameter int N_STAGES      = C_N_STAGES,
    parameter int HOLD_CYCLES   = C_HOLD_CYCLES,
    parameter int GAP_CYCLES    = C_GAP_CYCLES,
    parameter int READY_TIMEOUT = C_READY_TIMEOUT,
    parameter int CNT_W         = C_CNT_W
) (
    input  wire logic         clk,
    input  wire logic         resetPulse,
    reset_sequencer_if.slave  bus
);
    localparam int IDX_W     = idx_width(N_STAGES);
    localparam int C_MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ?
                               ((HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT) :
                               ((GAP_CYCLES > READY_TIMEOUT) ? GAP_CYCLES : READY_TIMEOUT);

    localparam logic [CNT_W-1:0] C_HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_GAP_LIM  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LIM   = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_STAGES - 1);

    if (C_MAX_CNT > (2 ** CNT_W) - 1) begin : g_cnt_w_check
        $error("reset_sequencer: CNT_W too small for the configured cycle counts");
    end

    state_t              r_state,       w_state_nxt;
    logic [IDX_W-1:0]    r_idx,         w_idx_nxt;
    logic [N_STAGES-1:0] r_stage_rst_n, w_stage_rst_n_nxt;
    logic                r_sys_ready,   w_sys_ready_nxt;
    logic                r_fault,       w_fault_nxt;
    logic [IDX_W-1:0]    r_fault_stage, w_fault_stage_nxt;

    logic             w_timer_clear_req;
    logic             w_timer_en;
    logic [CNT_W-1:0] w_timer_limit;
    logic             w_timer_tc;

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .clear  (!resetPulse || w_timer_clear_req),
        .enable (w_timer_en),
        .limit  (w_timer_limit),
        .tc     (w_timer_tc)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_stage_rst_n_nxt = r_stage_rst_n;
        w_sys_ready_nxt   = r_sys_ready;
        w_fault_nxt       = r_fault;
        w_fault_stage_nxt = r_fault_stage;
        w_timer_clear_req = 1'b0;
        w_timer_en        = 1'b0;
        w_timer_limit     = '0;

        if (bus.swResetReq) begin
            // Held request keeps the hold counter parked at zero
            w_state_nxt       = ST_HOLD;
            w_idx_nxt         = '0;
            w_stage_rst_n_nxt = '0;
            w_sys_ready_nxt   = 1'b0;
            w_fault_nxt       = 1'b0;
            w_fault_stage_nxt = '0;
            w_timer_clear_req = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_timer_en    = 1'b1;
                    w_timer_limit = C_HOLD_LIM;
                    if (w_timer_tc) w_state_nxt = ST_RELEASE;
                end
                ST_RELEASE: begin
                    w_stage_rst_n_nxt[r_idx] = 1'b1;
                    w_timer_clear_req        = 1'b1;
                    w_state_nxt              = ST_WAIT_READY;
                end
                ST_WAIT_READY: begin
                    w_timer_en    = 1'b1;
                    w_timer_limit = C_TO_LIM;
                    // Timeout outranks an ack landing on the same edge
                    if (w_timer_tc) begin
                        w_state_nxt       = ST_FAULT;
                        w_fault_nxt       = 1'b1;
                        w_fault_stage_nxt = r_idx;
                        w_sys_ready_nxt   = 1'b0;
                        w_stage_rst_n_nxt = '0;
                    end else if (bus.stageReady[r_idx]) begin
                        if (r_idx == C_LAST_IDX) begin
                            w_state_nxt     = ST_DONE;
                            w_sys_ready_nxt = 1'b1;
                        end else begin
                            w_state_nxt       = ST_GAP;
                            w_timer_clear_req = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    w_timer_en    = 1'b1;
                    w_timer_limit = C_GAP_LIM;
                    if (w_timer_tc) begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = ST_RELEASE;
                    end
                end
                ST_DONE: begin
                    if (!(&bus.stageReady)) begin
                        w_state_nxt       = ST_FAULT;
                        w_fault_nxt       = 1'b1;
                        w_sys_ready_nxt   = 1'b0;
                        w_stage_rst_n_nxt = '0;
                        for (int i = N_STAGES - 1; i >= 0; i--) begin
                            if (!bus.stageReady[i]) w_fault_stage_nxt = IDX_W'(i);
                        end
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt       = ST_FAULT;
                    w_fault_nxt       = 1'b1;
                    w_sys_ready_nxt   = 1'b0;
                    w_stage_rst_n_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetPulse) begin
            r_state       <= ST_HOLD;
            r_idx         <= '0;
            r_stage_rst_n <= '0;
            r_sys_ready   <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_stage_rst_n <= w_stage_rst_n_nxt;
            r_sys_ready   <= w_sys_ready_nxt;
            r_fault       <= w_fault_nxt;
            r_fault_stage <= w_fault_stage_nxt;
        end
    end

    assign bus.stageRstN  = r_stage_rst_n;
    assign bus.sysReady   = r_sys_ready;
    assign bus.fault      = r_fault;
    assign bus.faultStage = r_fault_stage;
endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// tb_reset_sequencer : directed scenarios plus randomized acks vs. timestamp model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int N = C_N_STAGES;

    logic clk        = 1'b0;
    logic resetPulse = 1'b0;
    always #4 clk = ~clk;

    reset_sequencer_if #(.N_STAGES(N)) bus ();

    reset_sequencer #(
        .N_STAGES      (N),
        .HOLD_CYCLES   (C_HOLD_CYCLES),
        .GAP_CYCLES    (C_GAP_CYCLES),
        .READY_TIMEOUT (C_READY_TIMEOUT),
        .CNT_W         (C_CNT_W)
    ) dut (
        .clk        (clk),
        .resetPulse (resetPulse),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ack responder: each stage acks a set number of cycles after its release
    int          ack_dly [N];
    logic [N-1:0] ack_never = '0;
    logic [N-1:0] tie_high  = '0;
    logic [N-1:0] drop_mask = '0;
    int          rcnt [N];

    initial begin
        logic [N-1:0] nxt;
        bus.stageReady = '0;
        for (int i = 0; i < N; i++) rcnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (!bus.stageRstN[i]) rcnt[i] = 0;
                else if (rcnt[i] < 100000) rcnt[i]++;
                nxt[i] = tie_high[i] |
                         (!ack_never[i] && bus.stageRstN[i] && (rcnt[i] >= ack_dly[i]));
                if (drop_mask[i]) nxt[i] = 1'b0;
            end
            bus.stageReady = nxt;
        end
    end

    // Timestamp model: each event is scheduled as an absolute edge number
    int           cyc      = 0;
    int           rel_due  = 0;
    int           deadline = 0;
    int           nrel     = 0;
    bit           waiting  = 0;
    bit           m_done   = 0;
    bit           m_valid  = 0;
    logic [N-1:0] m_rst_n  = '0;
    logic         m_sys    = 1'b0;
    logic         m_fault  = 1'b0;
    logic [1:0]   m_fstage = '0;

    always @(posedge clk) begin
        cyc++;
        m_valid = 1;
        if (!resetPulse || bus.swResetReq) begin
            m_rst_n = '0; m_sys = 0; m_fault = 0; m_fstage = '0;
            nrel = 0; waiting = 0; m_done = 0;
            rel_due = cyc + C_HOLD_CYCLES + 1;
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (m_done) begin
            if (bus.stageReady != {N{1'b1}}) begin
                m_fault = 1; m_sys = 0; m_rst_n = '0; m_done = 0;
                for (int i = N - 1; i >= 0; i--)
                    if (!bus.stageReady[i]) m_fstage = 2'(i);
            end
        end else if (waiting) begin
            if (cyc == deadline) begin
                m_fault = 1; m_sys = 0; m_rst_n = '0; waiting = 0;
                m_fstage = 2'(nrel);
            end else if (bus.stageReady[nrel]) begin
                waiting = 0;
                if (nrel == N - 1) begin
                    m_done = 1; m_sys = 1;
                end else begin
                    nrel++;
                    rel_due = cyc + C_GAP_CYCLES + 1;
                end
            end
        end else if (cyc == rel_due) begin
            m_rst_n[nrel] = 1'b1;
            waiting  = 1;
            deadline = cyc + C_READY_TIMEOUT;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("stageRstN", 32'(bus.stageRstN), 32'(m_rst_n));
            chk("sysReady", 32'(bus.sysReady), 32'(m_sys));
            chk("fault", 32'(bus.fault), 32'(m_fault));
            chk("faultStage", 32'(bus.faultStage), 32'(m_fstage));
            if (m_fault) chk("state_fault", 32'(dut.r_state), 32'(ST_FAULT));
        end
    end

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic at(input int target);
        while (k < target) tick();
    endtask

    task automatic sw_pulse(input int len);
        bus.swResetReq = 1'b1;
        repeat (len) tick();
        bus.swResetReq = 1'b0;
        k = -1;
    endtask

    initial begin
        int guard;
        int len;
        bus.swResetReq = 1'b0;
        for (int i = 0; i < N; i++) ack_dly[i] = 5;

        // Nominal sequence: k=0 is the first edge with resetPulse high
        repeat (10) @(negedge clk);
        resetPulse = 1'b1;
        k = -1;
        at(119); chk("t1_rstn_119", 32'(bus.stageRstN), 32'h0);
        at(120); chk("t1_rstn_120", 32'(bus.stageRstN), 32'h1);
        at(137); chk("t1_rstn_137", 32'(bus.stageRstN), 32'h1);
        at(138); chk("t1_rstn_138", 32'(bus.stageRstN), 32'h3);
        at(155); chk("t1_rstn_155", 32'(bus.stageRstN), 32'h3);
        at(156); chk("t1_rstn_156", 32'(bus.stageRstN), 32'h7);
        at(160); chk("t1_sys_160", 32'(bus.sysReady), 32'h0);
        at(161); chk("t1_sys_161", 32'(bus.sysReady), 32'h1);

        // Stage 1 never acks
        ack_never = 3'b010;
        sw_pulse(1);
        at(138);  chk("t2_rstn_138", 32'(bus.stageRstN), 32'h3);
        at(1337); chk("t2_fault_1337", 32'(bus.fault), 32'h0);
        at(1338); chk("t2_fault_1338", 32'(bus.fault), 32'h1);
        chk("t2_fstage", 32'(bus.faultStage), 32'h1);
        chk("t2_rstn", 32'(bus.stageRstN), 32'h0);
        chk("t2_sys", 32'(bus.sysReady), 32'h0);
        repeat (5000) tick();
        chk("t2_fault_held", 32'(bus.fault), 32'h1);

        // Recovery through a 3-cycle software request
        ack_never = '0;
        bus.swResetReq = 1'b1;
        tick();
        chk("t3_fault_clear", 32'(bus.fault), 32'h0);
        tick(); tick();
        bus.swResetReq = 1'b0;
        k = -1;
        at(119); chk("t3_rstn_119", 32'(bus.stageRstN), 32'h0);
        at(120); chk("t3_rstn_120", 32'(bus.stageRstN), 32'h1);
        at(161); chk("t3_sys_161", 32'(bus.sysReady), 32'h1);

        // Ack loss in DONE
        at(170);
        drop_mask = 3'b100;
        tick();
        drop_mask = '0;
        chk("t4_fault_pre", 32'(bus.fault), 32'h0);
        tick();
        chk("t4_fault", 32'(bus.fault), 32'h1);
        chk("t4_fstage", 32'(bus.faultStage), 32'h2);
        chk("t4_rstn", 32'(bus.stageRstN), 32'h0);

        // Reset (with simultaneous software request) during the first gap
        sw_pulse(1);
        at(130);
        chk("t5_rstn_gap", 32'(bus.stageRstN), 32'h1);
        resetPulse = 1'b0;
        bus.swResetReq = 1'b1;
        tick();
        chk("t5_rstn", 32'(bus.stageRstN), 32'h0);
        chk("t5_sys", 32'(bus.sysReady), 32'h0);
        chk("t5_fault", 32'(bus.fault), 32'h0);
        resetPulse = 1'b1;
        bus.swResetReq = 1'b0;
        k = -1;
        at(119); chk("t5_rstn_119", 32'(bus.stageRstN), 32'h0);
        at(120); chk("t5_rstn_120", 32'(bus.stageRstN), 32'h1);
        at(161); chk("t5_sys_161", 32'(bus.sysReady), 32'h1);

        // Stage 1 ack tied high from the start
        tie_high = 3'b010;
        sw_pulse(1);
        at(137); chk("t6_rstn_137", 32'(bus.stageRstN), 32'h1);
        at(138); chk("t6_rstn_138", 32'(bus.stageRstN), 32'h3);
        at(151); chk("t6_rstn_151", 32'(bus.stageRstN), 32'h3);
        at(152); chk("t6_rstn_152", 32'(bus.stageRstN), 32'h7);
        at(156); chk("t6_sys_156", 32'(bus.sysReady), 32'h0);
        at(157); chk("t6_sys_157", 32'(bus.sysReady), 32'h1);
        tie_high = '0;

        // Randomized ack timing, timeouts, restarts and drops
        for (int it = 0; it < 12; it++) begin
            for (int s = 0; s < N; s++) ack_dly[s] = $urandom_range(1, 30);
            ack_never = ($urandom_range(0, 4) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            tie_high  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                resetPulse = 1'b0;
                bus.swResetReq = 1'($urandom_range(0, 1));
            end else begin
                bus.swResetReq = 1'b1;
            end
            repeat (len) tick();
            resetPulse = 1'b1;
            bus.swResetReq = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(50, 200)) tick();
                bus.swResetReq = 1'b1;
                tick();
                bus.swResetReq = 1'b0;
            end
            guard = 0;
            while (!(m_done || m_fault) && guard < 3000) begin
                tick();
                guard++;
            end
            chk("rand_settle", 32'(guard < 3000), 32'h1);
            if (m_done && ($urandom_range(0, 1) == 1)) begin
                drop_mask = N'($urandom_range(1, 7));
                tick();
                drop_mask = '0;
            end
            repeat (5) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
